// File: rtl/saturn_periph_pkg.sv
// Shared Saturn peripheral types and constants.
// Used by the lightgun control-port / external-latch block.
package saturn_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PULSE,
    ST_HOLD
  } gun_st_e;

  localparam int PIN_TH = 6;
  localparam int PIN_TL = 5;
  localparam int PIN_TR = 4;

  localparam logic [3:0] GUN_ID_DEF = 4'b1010;

endpackage

// File: rtl/gun_port_exlat_if.sv
// Lightgun port bundle between the SMPC/VDP2 side and the gun block.
// master drives gun/SMPC inputs, slave is the gun block.
interface gun_port_exlat_if;
  logic       sensor;
  logic       btn_trig;
  logic       btn_start;
  logic       vblank;
  logic       exlat_en;
  logic [6:0] pdr;
  logic [6:0] ddr;
  logic [6:0] pin_in;
  logic       exlat_n;
  logic       latched;
  logic [7:0] latch_cnt;

  modport master (
    output sensor, btn_trig, btn_start,
    output vblank, exlat_en, pdr, ddr,
    input  pin_in, exlat_n, latched, latch_cnt
  );

  modport slave (
    input  sensor, btn_trig, btn_start,
    input  vblank, exlat_en, pdr, ddr,
    output pin_in, exlat_n, latched, latch_cnt
  );
endinterface

// File: rtl/gun_debounce.sv
// Single-bit stable-count filter: output follows input after
// DEBOUNCE consecutive cycles of disagreement.
module gun_debounce #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

  logic [7:0] r_cnt;
  logic       r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == LAST) begin
      r_cnt <= 8'd0;
      r_q   <= i_d;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gun_port_exlat.sv
// Lightgun control-port pin image and one-per-frame
// VDP2 external-latch strobe generator.
module gun_port_exlat
  import saturn_periph_pkg::*;
#(
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned DEBOUNCE   = 16,
  parameter int unsigned TH_STRETCH = 200,
  parameter logic [3:0]  GUN_ID     = GUN_ID_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  gun_port_exlat_if.slave io_bus
);

  localparam logic [3:0] PLAST = 4'(PULSE_LEN - 1);
  localparam logic [9:0] TH_LD = 10'(TH_STRETCH);

  gun_st_e    r_state;
  gun_st_e    w_state_nxt;
  logic       r_sensor_q;
  logic       r_vblank_q;
  logic [3:0] r_pcnt;
  logic       r_exlat_n;
  logic       r_latched;
  logic [7:0] r_cnt;
  logic [9:0] r_th_cnt;
  logic [6:0] r_pin;

  logic       w_sen_rise;
  logic       w_vb_rise;
  logic       w_trig_db;
  logic       w_fire;
  logic       w_exlat_n_nxt;
  logic       w_th_active;
  logic [6:0] w_img;
  logic [6:0] w_rst_img;

  gun_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_trig_db (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (io_bus.btn_trig),
    .o_q     (w_trig_db)
  );

  assign w_sen_rise = io_bus.sensor & ~r_sensor_q;
  assign w_vb_rise  = io_bus.vblank & ~r_vblank_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (io_bus.exlat_en) w_state_nxt = ST_ARMED;
      ST_ARMED:
        if (w_sen_rise && w_trig_db) w_state_nxt = ST_PULSE;
      ST_PULSE:
        if (r_pcnt == PLAST) w_state_nxt = ST_HOLD;
      ST_HOLD:
        if (w_vb_rise) w_state_nxt = ST_ARMED;
      default:
        w_state_nxt = ST_IDLE;
    endcase
    // Disabling latching overrides every state, truncating a pulse.
    if (!io_bus.exlat_en) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_fire        = (r_state == ST_ARMED) && (w_state_nxt == ST_PULSE);
    w_exlat_n_nxt = (w_state_nxt != ST_PULSE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sensor_q <= 1'b0;
      r_vblank_q <= 1'b0;
      r_pcnt     <= 4'd0;
      r_exlat_n  <= 1'b1;
      r_latched  <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_sensor_q <= io_bus.sensor;
      r_vblank_q <= io_bus.vblank;
      r_exlat_n  <= w_exlat_n_nxt;
      r_pcnt     <= (r_state == ST_PULSE) ? r_pcnt + 4'd1 : 4'd0;
      if (w_fire)         r_latched <= 1'b1;
      else if (w_vb_rise) r_latched <= 1'b0;
      if (w_fire && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           r_th_cnt <= 10'd0;
    else if (io_bus.sensor) r_th_cnt <= TH_LD;
    else if (r_th_cnt != 0) r_th_cnt <= r_th_cnt - 10'd1;
  end

  assign w_th_active = io_bus.sensor | (r_th_cnt != 10'd0);

  always_comb begin
    w_img         = {3'b111, GUN_ID};
    w_img[PIN_TH] = ~w_th_active;
    w_img[PIN_TL] = ~io_bus.btn_start;
    w_img[PIN_TR] = ~w_trig_db;
    w_rst_img     = {3'b111, GUN_ID};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_pin <= (io_bus.ddr & io_bus.pdr) | (~io_bus.ddr & w_rst_img);
    else
      r_pin <= (io_bus.ddr & io_bus.pdr) | (~io_bus.ddr & w_img);
  end

  assign io_bus.pin_in    = r_pin;
  assign io_bus.exlat_n   = r_exlat_n;
  assign io_bus.latched   = r_latched;
  assign io_bus.latch_cnt = r_cnt;

endmodule

// File: tb/tb_gun_port_exlat.sv
// Self-checking bench for gun_port_exlat: pin-image vector table
// plus hand-written latch, debounce, stretch and reset sequences.
module tb_gun_port_exlat;

  logic clk = 1'b0;
  logic rst_n;
  int   nerr = 0;
  int   nchk = 0;

  logic [6:0] sb_pin[$];
  logic       sb_ex[$];

  gun_port_exlat_if bus();

  gun_port_exlat dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ddr;
    logic [6:0] pdr;
    logic       start;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[7];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic vb_pulse();
    bus.vblank = 1'b1;
    step();
    bus.vblank = 1'b0;
    step();
  endtask

  // One-cycle SENSOR pulse; EXLAT_N expected low for nlow cycles.
  task automatic sense_chk(input string nm, input int nlow,
                           input int ncyc);
    bus.sensor = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      sb_ex.push_back(i < nlow ? 1'b0 : 1'b1);
      step();
      bus.sensor = 1'b0;
      chk(nm, 32'(bus.exlat_n), 32'(sb_ex.pop_front()));
    end
  endtask

  initial begin
    vt[0] = '{7'h40, 7'h00, 1'b0, 7'h3A};
    vt[1] = '{7'h00, 7'h00, 1'b0, 7'h7A};
    vt[2] = '{7'h00, 7'h00, 1'b1, 7'h5A};
    vt[3] = '{7'h7F, 7'h55, 1'b1, 7'h55};
    vt[4] = '{7'h0F, 7'h05, 1'b0, 7'h75};
    vt[5] = '{7'h30, 7'h00, 1'b0, 7'h4A};
    vt[6] = '{7'h40, 7'h40, 1'b0, 7'h7A};

    rst_n         = 1'b0;
    bus.sensor    = 1'b0;
    bus.btn_trig  = 1'b0;
    bus.btn_start = 1'b0;
    bus.vblank    = 1'b0;
    bus.exlat_en  = 1'b0;
    bus.pdr       = 7'h00;
    bus.ddr       = 7'h00;
    steps(2);
    chk("rst_exlat_n", 32'(bus.exlat_n), 32'd1);
    chk("rst_latched", 32'(bus.latched), 32'd0);
    chk("rst_cnt", 32'(bus.latch_cnt), 32'd0);
    chk("rst_pin", 32'(bus.pin_in), 32'h7A);

    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.ddr       = vt[i].ddr;
      bus.pdr       = vt[i].pdr;
      bus.btn_start = vt[i].start;
      sb_pin.push_back(vt[i].exp);
      step();
      chk($sformatf("pin_vec%0d", i), 32'(bus.pin_in),
          32'(sb_pin.pop_front()));
    end
    bus.ddr       = 7'h00;
    bus.pdr       = 7'h00;
    bus.btn_start = 1'b0;

    bus.exlat_en = 1'b1;
    bus.btn_trig = 1'b1;
    steps(20);
    chk("pin_trig_on", 32'(bus.pin_in), 32'h6A);

    sense_chk("pulse1", 4, 6);
    chk("latched1", 32'(bus.latched), 32'd1);
    chk("cnt1", 32'(bus.latch_cnt), 32'd1);

    sense_chk("same_frame", 0, 6);
    chk("cnt_same_frame", 32'(bus.latch_cnt), 32'd1);

    vb_pulse();
    chk("latched_clr", 32'(bus.latched), 32'd0);
    sense_chk("pulse2", 4, 6);
    chk("cnt2", 32'(bus.latch_cnt), 32'd2);
    chk("latched2", 32'(bus.latched), 32'd1);

    vb_pulse();
    bus.vblank = 1'b1;
    bus.sensor = 1'b1;
    step();
    bus.vblank = 1'b0;
    bus.sensor = 1'b0;
    chk("set_wins", 32'(bus.latched), 32'd1);
    chk("set_wins_ex", 32'(bus.exlat_n), 32'd0);
    chk("cnt3", 32'(bus.latch_cnt), 32'd3);
    steps(5);

    vb_pulse();
    bus.btn_trig = 1'b0;
    steps(20);
    chk("tr_off", 32'(bus.pin_in[4]), 32'd1);
    bus.btn_trig = 1'b1;
    steps(10);
    bus.btn_trig = 1'b0;
    steps(3);
    chk("tr_glitch", 32'(bus.pin_in[4]), 32'd1);
    sense_chk("no_trig", 0, 6);
    chk("cnt_no_trig", 32'(bus.latch_cnt), 32'd3);

    bus.btn_trig = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i >= 15)
        chk($sformatf("tr_hold%0d", i), 32'(bus.pin_in[4]),
            (i >= 17) ? 32'd0 : 32'd1);
    end

    steps(210);
    chk("th_idle", 32'(bus.pin_in[6]), 32'd1);
    bus.sensor = 1'b1;
    for (int i = 1; i <= 210; i++) begin
      step();
      if (i == 3) bus.sensor = 1'b0;
      if (i == 1 || i == 3 || i == 100 || i == 203 ||
          i == 204 || i == 210)
        chk($sformatf("th_c%0d", i), 32'(bus.pin_in[6]),
            (i <= 203) ? 32'd0 : 32'd1);
    end

    vb_pulse();
    bus.sensor = 1'b1;
    step();
    bus.sensor = 1'b0;
    chk("drop_c1", 32'(bus.exlat_n), 32'd0);
    step();
    chk("drop_c2", 32'(bus.exlat_n), 32'd0);
    bus.exlat_en = 1'b0;
    step();
    chk("drop_off", 32'(bus.exlat_n), 32'd1);
    step();
    chk("drop_stay", 32'(bus.exlat_n), 32'd1);
    sense_chk("idle_ignore", 0, 4);

    bus.exlat_en = 1'b1;
    step();
    for (int i = 0; i < 260; i++) begin
      bus.sensor = 1'b1;
      step();
      bus.sensor = 1'b0;
      steps(5);
      vb_pulse();
    end
    chk("cnt_sat", 32'(bus.latch_cnt), 32'd255);

    bus.sensor = 1'b1;
    step();
    bus.sensor = 1'b0;
    step();
    chk("rstp_low", 32'(bus.exlat_n), 32'd0);
    rst_n = 1'b0;
    step();
    chk("rstp_exlat_n", 32'(bus.exlat_n), 32'd1);
    chk("rstp_latched", 32'(bus.latched), 32'd0);
    chk("rstp_cnt", 32'(bus.latch_cnt), 32'd0);
    chk("rstp_pin", 32'(bus.pin_in), 32'h7A);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
